sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO. It is the next generation of the team's 8-bit sync FIFO and adds:
- configurable width and depth
- occupancy count
- programmable almost-full and almost-empty flags
- sticky overflow and underflow error flags
- synchronous flush
- optional first-word-fall-through (FWFT) read mode

It sits between producer and consumer blocks in the same clock domain.

---
 rtl/sync_fifo_pkg.sv | 12 +
 rtl/fifo_mem_dp.sv | 39 +++
 rtl/sync_fifo_param.sv | 104 ++++++++++
 tb/tb_sync_fifo_param.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and sizing helpers for the parametrised sync FIFO.
package sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;

    // Occupancy needs one more bit than the pointers to represent "full".
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Simple dual-port storage: one synchronous write port, one read port that
// offers both the live head word and a registered copy captured on rd_en.
module fifo_mem_dp
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_head,
    output logic [DATA_WIDTH-1:0]    rd_data_p1
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_head = mem[rd_addr];

    // ---- read stage p1: registered word, also serves as last-popped value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_p1 <= '0;
        end else if (rd_en) begin
            rd_data_p1 <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, programmable threshold flags,
// sticky error flags, synchronous flush and optional first-word-fall-through.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          write_en,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          read_en,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] rd_data_p1;

    assign empty        = (count_q == '0);
    assign full         = (count_q == FULL_LVL);
    assign almost_full  = (count_q >= AF_LVL);
    assign almost_empty = (count_q <= AE_LVL);
    assign count        = count_q;

    // A full FIFO may still take a write when the same cycle frees a slot.
    assign rd_acc = read_en & ~empty;
    assign wr_acc = write_en & (~full | rd_acc);

    fifo_mem_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_acc & ~clear),
        .wr_addr    (wr_ptr),
        .wr_data    (data_in),
        .rd_en      (rd_acc & ~clear),
        .rd_addr    (rd_ptr),
        .rd_head    (head),
        .rd_data_p1 (rd_data_p1)
    );

    // FWFT shows the live head; an empty FIFO falls back to the last popped word.
    assign data_out = ((FWFT != 0) && !empty) ? head : rd_data_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (write_en && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (read_en && !rd_acc) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: a standard-read instance checked via an
// expected-data queue, plus an FWFT instance checked with directed values.
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Standard-mode instance
    logic          rst_n, clear, write_en, read_en;
    logic [DW-1:0] data_in, data_out;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [CW-1:0] count;

    // FWFT instance
    logic          rst_b, clear_b, write_en_b, read_en_b;
    logic [DW-1:0] data_in_b, data_out_b;
    logic          full_b, empty_b, almost_full_b, almost_empty_b, overflow_b, underflow_b;
    logic [CW-1:0] count_b;

    sync_fifo_param #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)
    ) u_std (
        .clk(clk), .reset(rst_n), .clear(clear), .write_en(write_en),
        .data_in(data_in), .read_en(read_en), .data_out(data_out),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_param #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)
    ) u_fwft (
        .clk(clk), .reset(rst_b), .clear(clear_b), .write_en(write_en_b),
        .data_in(data_in_b), .read_en(read_en_b), .data_out(data_out_b),
        .full(full_b), .empty(empty_b), .almost_full(almost_full_b),
        .almost_empty(almost_empty_b), .count(count_b),
        .overflow(overflow_b), .underflow(underflow_b)
    );

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] exp_q[$];
    logic          pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic cyc(input logic we, input logic [DW-1:0] d, input logic re);
        write_en = we;
        data_in  = d;
        read_en  = re;
        @(negedge clk);
    endtask

    task automatic cycb(input logic we, input logic [DW-1:0] d, input logic re);
        write_en_b = we;
        data_in_b  = d;
        read_en_b  = re;
        @(negedge clk);
    endtask

    // Monitor: an accepted read presents its word on data_out after the edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend <= 1'b0;
        else        pend <= read_en && !empty && !clear;
    end

    always @(negedge clk) begin : monitor
        logic [DW-1:0] e;
        if (pend) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_extra_pop: got %0d required no output", data_out);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", 32'(data_out), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; write_en = 1'b0; read_en = 1'b0; data_in = '0;
        rst_b = 1'b0; clear_b = 1'b0; write_en_b = 1'b0; read_en_b = 1'b0; data_in_b = '0;
        repeat (2) @(negedge clk);

        // 1. reset then idle
        rst_n = 1'b1;
        cyc(1'b0, 8'd0, 1'b0);
        chk("rst_empty",  32'(empty), 1);
        chk("rst_full",   32'(full), 0);
        chk("rst_count",  32'(count), 0);
        chk("rst_ae",     32'(almost_empty), 1);
        chk("rst_af",     32'(almost_full), 0);
        chk("rst_dout",   32'(data_out), 0);
        chk("rst_ovf",    32'(overflow), 0);
        chk("rst_udf",    32'(underflow), 0);

        // 2. fill, overflow, drain
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'(i));
            cyc(1'b1, 8'(i), 1'b0);
            if (i == 4) chk("af_at5", 32'(almost_full), 0);
            if (i == 5) chk("af_at6", 32'(almost_full), 1);
            if (i == 6) chk("full_at7", 32'(full), 0);
        end
        chk("fill_full",  32'(full), 1);
        chk("fill_count", 32'(count), 8);
        chk("fill_ae",    32'(almost_empty), 0);
        cyc(1'b1, 8'd99, 1'b0);
        chk("ovf_set",    32'(overflow), 1);
        chk("ovf_count",  32'(count), 8);
        for (int i = 0; i < 8; i++) cyc(1'b0, 8'd0, 1'b1);
        chk("drain_empty", 32'(empty), 1);
        chk("drain_dout",  32'(data_out), 7);

        // 3. underflow then clear
        cyc(1'b0, 8'd0, 1'b1);
        chk("udf_set",   32'(underflow), 1);
        chk("udf_count", 32'(count), 0);
        chk("udf_dout",  32'(data_out), 7);
        clear = 1'b1;
        cyc(1'b0, 8'd0, 1'b0);
        clear = 1'b0;
        chk("clr_udf",  32'(underflow), 0);
        chk("clr_ovf",  32'(overflow), 0);
        chk("clr_dout", 32'(data_out), 7);

        // 4. wrap-around
        for (int i = 30; i < 38; i++) begin
            exp_q.push_back(8'(i));
            cyc(1'b1, 8'(i), 1'b0);
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'd0, 1'b1);
        chk("wrap_count4", 32'(count), 4);
        for (int i = 40; i < 44; i++) begin
            exp_q.push_back(8'(i));
            cyc(1'b1, 8'(i), 1'b0);
        end
        chk("wrap_full", 32'(full), 1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 8'd0, 1'b1);
        chk("wrap_empty", 32'(empty), 1);
        chk("wrap_dout",  32'(data_out), 43);

        // 5. simultaneous read/write while full
        for (int i = 60; i < 68; i++) begin
            exp_q.push_back(8'(i));
            cyc(1'b1, 8'(i), 1'b0);
        end
        exp_q.push_back(8'd55);
        cyc(1'b1, 8'd55, 1'b1);
        chk("rw_count", 32'(count), 8);
        chk("rw_ovf",   32'(overflow), 0);
        chk("rw_full",  32'(full), 1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 8'd0, 1'b1);
        chk("rw_last",  32'(data_out), 55);
        chk("rw_empty", 32'(empty), 1);

        // 6. FWFT instance
        rst_b = 1'b1;
        cycb(1'b0, 8'd0, 1'b0);
        chk("fw_rst_dout",  32'(data_out_b), 0);
        chk("fw_rst_empty", 32'(empty_b), 1);
        cycb(1'b1, 8'hA5, 1'b0);
        chk("fw_head",  32'(data_out_b), 32'h A5);
        chk("fw_count", 32'(count_b), 1);
        cycb(1'b0, 8'd0, 1'b1);
        chk("fw_pop_empty", 32'(empty_b), 1);
        chk("fw_pop_hold",  32'(data_out_b), 32'h A5);
        for (int i = 0; i < 9; i++) cycb(1'b1, 8'(8'h10 + i), 1'b0);
        chk("fw_ovf",  32'(overflow_b), 1);
        chk("fw_full", 32'(full_b), 1);
        chk("fw_head2", 32'(data_out_b), 32'h 10);
        write_en_b = 1'b1;
        data_in_b  = 8'h20;
        #2 rst_b = 1'b0;
        #1;
        chk("fw_ar_full",  32'(full_b), 0);
        chk("fw_ar_empty", 32'(empty_b), 1);
        chk("fw_ar_count", 32'(count_b), 0);
        chk("fw_ar_ovf",   32'(overflow_b), 0);
        chk("fw_ar_ae",    32'(almost_empty_b), 1);
        chk("fw_ar_af",    32'(almost_full_b), 0);
        chk("fw_ar_dout",  32'(data_out_b), 0);
        @(negedge clk);
        rst_b = 1'b1;
        cycb(1'b0, 8'd0, 1'b0);
        chk("fw_post_count", 32'(count_b), 0);
        chk("fw_post_empty", 32'(empty_b), 1);

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
